param_mem: RTL and testbench
============================

# param_mem

Parametrised single-clock RAM that succeeds the fixed 256×18 address-in/data-out memory. It adds a write port, a configurable read pipeline (1 or 2 cycles) with a valid strobe, and out-of-range detection for non-power-of-two depths. A hardware clear sequencer zeroes every word after each reset. It sits wherever the design needs a small table written by one agent and read by another in the same clock domain.

## Interface
- DATA_W, 18, word width in bits (1..64)
- ADDR_W, 8, address width in bits (1..16)
- DEPTH, 256, number of words; 2 ≤ DEPTH ≤ 2^ADDR_W
- RD_LAT, 1, read latency in cycles; legal values 1 or 2, anything else is an elaboration error
- WR_FIRST, 1, read-during-write to the same address: 1 returns new data, 0 returns old data

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ready  out  1  high when requests are accepted (state RUN)
- wr_en  in  1  write request, sampled when ready=1
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_err  out  1  one-cycle pulse: previous-cycle accepted write was out of range
- rd_en  in  1  read request, sampled when ready=1
- rd_addr  in  ADDR_W  read address
- rd_valid  out  1  one-cycle pulse, rd_data/rd_err valid
- rd_data  out  DATA_W  read data
- rd_err  out  1  qualifies rd_valid: address was out of range

## Operation
- States: CLEAR, RUN. rst_n low forces CLEAR with clear counter = 0.
- CLEAR: each rising edge writes 0 to mem[counter] and increments the counter. The edge that writes DEPTH-1 moves to RUN. ready=0 throughout CLEAR.
- RUN: ready=1. Stays in RUN until rst_n is asserted; there is no other exit.
- wr_en/rd_en with ready=0 are dropped: no write, no rd_valid, no wr_err.
- Write: wr_en and wr_addr < DEPTH updates mem at the edge. wr_addr ≥ DEPTH leaves memory unchanged and pulses wr_err on the next cycle.
- Read: rd_en accepted → rd_valid pulses RD_LAT cycles later.
  - rd_addr < DEPTH: rd_data = word, rd_err = 0.
  - rd_addr ≥ DEPTH: rd_data = 0, rd_err = 1.
- One read and one write may be accepted in the same cycle.
- Same-address read-during-write: WR_FIRST=1 → rd_data = wr_data; WR_FIRST=0 → previous contents. An out-of-range write never bypasses.
- Reads are fully pipelined: one accepted per cycle, responses in request order.
- rd_data and rd_err hold their last value while rd_valid=0.

## Timing
- Reset values (rst_n low): ready=0, rd_valid=0, rd_data=0, rd_err=0, wr_err=0. The read pipeline is flushed.
- After rst_n rises, the clear takes DEPTH edges. ready rises after the DEPTH-th edge; the first request can be accepted on edge DEPTH+1.
- Reset during CLEAR or RUN aborts everything: in-flight reads never produce rd_valid, the clear restarts at address 0, and all prior contents are lost.
- RD_LAT=1: request at edge n → rd_valid high from edge n+1 to edge n+2.
- RD_LAT=2: request at edge n → rd_valid high from edge n+2 to edge n+3. The RAM output is registered once more.
- wr_err latency: exactly 1 cycle after the accepting edge.
- Write-to-read visibility: a write at edge n is returned by a read accepted at edge n+1 for either WR_FIRST value. With WR_FIRST=1 it is also returned by a read accepted at edge n.

## Test plan
- Reset release, DEPTH=200: ready rises exactly 200 edges after rst_n rises. Reading addresses 0, 5 and 199 returns 0 with rd_err=0.
- Write 0x2ABCD to address 1, read address 1 on the next cycle, RD_LAT=1: rd_valid one cycle later with rd_data=0x2ABCD.
- Address 2 holds 0x00011; same-cycle write 0x3FFFF and read of address 2: WR_FIRST=1 → 0x3FFFF, WR_FIRST=0 → 0x00011.
- DEPTH=200, read address 250 → rd_valid with rd_err=1 and rd_data=0. Write to address 230 → wr_err pulse, and a later read of address 230 still reports rd_err=1.
- RD_LAT=2, back-to-back reads of addresses 1, 2, 3 holding 0x11, 0x22, 0x33: rd_valid high on three consecutive cycles starting 2 cycles after the first request, with data 0x11, 0x22, 0x33 in order.
- Write 0x2ABCD to address 1, then assert rst_n for 1 cycle while a read is in flight and again at clear count 50. No rd_valid appears, ready rises 200 edges after the final release, and address 1 reads 0.

Source files
------------

// File: rtl/param_mem_if.sv
// Request/response bundle for param_mem: one write port and one pipelined read port.
// Handshake: requests are accepted on a rising edge only while ready=1 (ready acts as the
// sink's readiness for both wr_en and rd_en); rd_valid is a one-cycle strobe with no backpressure.
interface param_mem_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 8
);
  logic              ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;

  modport master (
    input  ready, wr_err, rd_valid, rd_data, rd_err,
    output wr_en, wr_addr, wr_data, rd_en, rd_addr
  );

  modport slave (
    output ready, wr_err, rd_valid, rd_data, rd_err,
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr
  );
endinterface

// File: rtl/param_mem.sv
// Single-clock parametrised RAM with a post-reset clear sequencer, a 1- or 2-cycle
// read pipeline with valid strobe, and out-of-range detection for non-power-of-two depths.
module param_mem #(
  parameter int DATA_W   = 18,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int RD_LAT   = 1,
  parameter bit WR_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  param_mem_if.slave   bus,
  output logic         state_dbg
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              wr_acc, wr_ok, rd_acc, rd_ok, bypass;
  logic [DATA_W-1:0] rd_word;
  logic              s1_valid, s1_err;
  logic [DATA_W-1:0] s1_data;

  assign state_dbg = state;
  assign bus.ready = (state == ST_RUN);

  // Requests only count in RUN; the address compare is one bit wider so DEPTH = 2^ADDR_W works.
  assign wr_acc = (state == ST_RUN) && bus.wr_en;
  assign rd_acc = (state == ST_RUN) && bus.rd_en;
  assign wr_ok  = wr_acc && ({1'b0, bus.wr_addr} < DEPTH_X);
  assign rd_ok  = rd_acc && ({1'b0, bus.rd_addr} < DEPTH_X);
  assign bypass = WR_FIRST && wr_ok && (bus.wr_addr == bus.rd_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) state <= ST_RUN;
        end
        ST_RUN:   state <= ST_RUN;
        default:  state <= ST_CLEAR;
      endcase
    end
  end

  // Storage carries no reset; the clear sequencer owns the port while in CLEAR.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) mem[clr_cnt[IDX_W-1:0]] <= '0;
    else if (wr_ok)        mem[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.wr_err <= 1'b0;
    else        bus.wr_err <= wr_acc && !wr_ok;
  end

  always_comb begin
    rd_word = '0;
    if (rd_ok) rd_word = bypass ? bus.wr_data : mem[bus.rd_addr[IDX_W-1:0]];
  end

  // First read stage: data/err only move on an accepted read, so they hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_data <= rd_word;
        s1_err  <= !rd_ok;
      end
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign bus.rd_valid = s1_valid;
      assign bus.rd_data  = s1_data;
      assign bus.rd_err   = s1_err;
    end else if (RD_LAT == 2) begin : g_lat2
      logic              s2_valid, s2_err;
      logic [DATA_W-1:0] s2_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
          s2_err   <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
            s2_err  <= s1_err;
          end
        end
      end

      assign bus.rd_valid = s2_valid;
      assign bus.rd_data  = s2_data;
      assign bus.rd_err   = s2_err;
    end else begin : g_bad_lat
      $error("param_mem: RD_LAT must be 1 or 2");
    end
  endgenerate

endmodule

// File: tb/tb_param_mem.sv
// Directed bench for param_mem: two instances (RD_LAT=1/WR_FIRST=1 and RD_LAT=2/WR_FIRST=0,
// both DEPTH=200) receive identical stimulus and are checked against hand-computed values.
module tb_param_mem;

  logic clk = 1'b0;
  logic rst_n;
  logic dbg_a, dbg_b;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  param_mem_if #(.DATA_W(18), .ADDR_W(8)) ia ();
  param_mem_if #(.DATA_W(18), .ADDR_W(8)) ib ();

  param_mem #(.DATA_W(18), .ADDR_W(8), .DEPTH(200), .RD_LAT(1), .WR_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave), .state_dbg(dbg_a)
  );

  param_mem #(.DATA_W(18), .ADDR_W(8), .DEPTH(200), .RD_LAT(2), .WR_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave), .state_dbg(dbg_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [7:0] wa, input logic [17:0] wd,
                       input logic re, input logic [7:0] ra);
    ia.wr_en = we; ia.wr_addr = wa; ia.wr_data = wd; ia.rd_en = re; ia.rd_addr = ra;
    ib.wr_en = we; ib.wr_addr = wa; ib.wr_data = wd; ib.rd_en = re; ib.rd_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 8'd0, 18'd0, 1'b0, 8'd0);
  endtask

  // Read-port expectation for both instances; data/err only checked when a strobe is expected.
  task automatic expect_rd(input string tag,
                           input logic av, input logic [17:0] ad, input logic ae,
                           input logic bv, input logic [17:0] bd, input logic be);
    chk({tag, " a.rd_valid"}, 32'(ia.rd_valid), 32'(av));
    if (av) begin
      chk({tag, " a.rd_data"}, 32'(ia.rd_data), 32'(ad));
      chk({tag, " a.rd_err"},  32'(ia.rd_err),  32'(ae));
    end
    chk({tag, " b.rd_valid"}, 32'(ib.rd_valid), 32'(bv));
    if (bv) begin
      chk({tag, " b.rd_data"}, 32'(ib.rd_data), 32'(bd));
      chk({tag, " b.rd_err"},  32'(ib.rd_err),  32'(be));
    end
  endtask

  task automatic wait_ready(input string tag);
    int   k    = 0;
    logic seen = 1'b0;
    do begin
      tick();
      k++;
      seen = seen | ia.rd_valid | ib.rd_valid | ia.wr_err | ib.wr_err;
    end while (!(ia.ready && ib.ready) && k < 1000);
    chk({tag, " clear edges"}, 32'(k), 32'd200);
    chk({tag, " no strobe in clear"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    // Reset: requests held high must be ignored
    rst_n = 1'b0;
    drive(1'b1, 8'd5, 18'h3, 1'b1, 8'd0);
    repeat (3) tick();
    chk("rst a.ready",    32'(ia.ready),    32'd0);
    chk("rst b.ready",    32'(ib.ready),    32'd0);
    chk("rst a.rd_valid", 32'(ia.rd_valid), 32'd0);
    chk("rst b.rd_valid", 32'(ib.rd_valid), 32'd0);
    chk("rst a.rd_data",  32'(ia.rd_data),  32'd0);
    chk("rst b.rd_data",  32'(ib.rd_data),  32'd0);
    chk("rst a.rd_err",   32'(ia.rd_err),   32'd0);
    chk("rst a.wr_err",   32'(ia.wr_err),   32'd0);
    chk("rst b.wr_err",   32'(ib.wr_err),   32'd0);
    chk("rst a.state",    32'(dbg_a),       32'd0);

    // Clear with write/read requests still asserted: all dropped
    rst_n = 1'b1;
    wait_ready("boot");
    chk("boot a.state", 32'(dbg_a), 32'd1);

    // Cleared contents, including the word a dropped write targeted
    drive(1'b0, 8'd0, 18'd0, 1'b1, 8'd0);   tick(); expect_rd("rd0",   1, 18'h0, 0, 0, 18'h0, 0);
    drive(1'b0, 8'd0, 18'd0, 1'b1, 8'd5);   tick(); expect_rd("rd5",   1, 18'h0, 0, 1, 18'h0, 0);
    drive(1'b0, 8'd0, 18'd0, 1'b1, 8'd199); tick(); expect_rd("rd199", 1, 18'h0, 0, 1, 18'h0, 0);
    idle(); tick(); expect_rd("rd199 tail", 0, 18'h0, 0, 1, 18'h0, 0);
    tick();         expect_rd("idle1",      0, 18'h0, 0, 0, 18'h0, 0);

    // Write then read on the next cycle
    drive(1'b1, 8'd1, 18'h2ABCD, 1'b0, 8'd0); tick();
    chk("wr1 a.wr_err", 32'(ia.wr_err), 32'd0);
    chk("wr1 b.wr_err", 32'(ib.wr_err), 32'd0);
    drive(1'b0, 8'd0, 18'd0, 1'b1, 8'd1); tick(); expect_rd("rd1", 1, 18'h2ABCD, 0, 0, 18'h0, 0);
    idle(); tick(); expect_rd("rd1 tail", 0, 18'h0, 0, 1, 18'h2ABCD, 0);

    // Same-cycle read and write of address 2
    drive(1'b1, 8'd2, 18'h00011, 1'b0, 8'd0); tick();
    drive(1'b1, 8'd2, 18'h3FFFF, 1'b1, 8'd2); tick(); expect_rd("rdw", 1, 18'h3FFFF, 0, 0, 18'h0, 0);
    idle(); tick(); expect_rd("rdw tail", 0, 18'h0, 0, 1, 18'h00011, 0);
    drive(1'b0, 8'd0, 18'd0, 1'b1, 8'd2); tick(); expect_rd("rd2", 1, 18'h3FFFF, 0, 0, 18'h0, 0);
    idle(); tick(); expect_rd("rd2 tail", 0, 18'h0, 0, 1, 18'h3FFFF, 0);

    // Out-of-range read and write
    drive(1'b0, 8'd0, 18'd0, 1'b1, 8'd250); tick(); expect_rd("rd250", 1, 18'h0, 1, 0, 18'h0, 0);
    idle(); tick(); expect_rd("rd250 tail", 0, 18'h0, 0, 1, 18'h0, 1);
    drive(1'b1, 8'd230, 18'h1234, 1'b0, 8'd0); tick();
    chk("wr230 a.wr_err", 32'(ia.wr_err), 32'd1);
    chk("wr230 b.wr_err", 32'(ib.wr_err), 32'd1);
    idle(); tick();
    chk("wr230 a.wr_err end", 32'(ia.wr_err), 32'd0);
    chk("wr230 b.wr_err end", 32'(ib.wr_err), 32'd0);
    drive(1'b0, 8'd0, 18'd0, 1'b1, 8'd230); tick(); expect_rd("rd230", 1, 18'h0, 1, 0, 18'h0, 0);
    idle(); tick(); expect_rd("rd230 tail", 0, 18'h0, 0, 1, 18'h0, 1);

    // Back-to-back reads, ordering and latency
    drive(1'b1, 8'd1, 18'h11, 1'b0, 8'd0); tick();
    drive(1'b1, 8'd2, 18'h22, 1'b0, 8'd0); tick();
    drive(1'b1, 8'd3, 18'h33, 1'b0, 8'd0); tick();
    drive(1'b0, 8'd0, 18'd0, 1'b1, 8'd1); tick(); expect_rd("b2b1", 1, 18'h11, 0, 0, 18'h0,  0);
    drive(1'b0, 8'd0, 18'd0, 1'b1, 8'd2); tick(); expect_rd("b2b2", 1, 18'h22, 0, 1, 18'h11, 0);
    drive(1'b0, 8'd0, 18'd0, 1'b1, 8'd3); tick(); expect_rd("b2b3", 1, 18'h33, 0, 1, 18'h22, 0);
    idle(); tick(); expect_rd("b2b tail", 0, 18'h0, 0, 1, 18'h33, 0);
    tick();         expect_rd("b2b idle", 0, 18'h0, 0, 0, 18'h0,  0);

    // Reset with a read in flight, then again partway through the clear
    drive(1'b1, 8'd1, 18'h2ABCD, 1'b0, 8'd0); tick();
    drive(1'b0, 8'd0, 18'd0, 1'b1, 8'd1); tick(); expect_rd("pre-rst", 1, 18'h2ABCD, 0, 0, 18'h0, 0);
    rst_n = 1'b0;
    idle();
    #1;
    chk("abort a.rd_valid", 32'(ia.rd_valid), 32'd0);
    chk("abort b.rd_valid", 32'(ib.rd_valid), 32'd0);
    chk("abort a.rd_data",  32'(ia.rd_data),  32'd0);
    chk("abort a.ready",    32'(ia.ready),    32'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      seen = seen | ia.rd_valid | ib.rd_valid | ia.ready | ib.ready;
    end
    chk("partial clear quiet", 32'(seen), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_ready("reclear");
    drive(1'b0, 8'd0, 18'd0, 1'b1, 8'd1); tick(); expect_rd("rd1 lost", 1, 18'h0, 0, 0, 18'h0, 0);
    idle(); tick(); expect_rd("rd1 lost tail", 0, 18'h0, 0, 1, 18'h0, 0);
    tick();         expect_rd("final idle",    0, 18'h0, 0, 0, 18'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
